// File: rtl/uart_buffered_pkg.sv
// Shared definitions for the buffered UART: register map, LSR/IER bit
// positions, the common TX/RX state encoding and divisor helpers.
package uart_buffered_pkg;

  localparam logic [31:0] OFF_DATA = 32'h00;
  localparam logic [31:0] OFF_LSR  = 32'h04;
  localparam logic [31:0] OFF_DIVR = 32'h08;
  localparam logic [31:0] OFF_DIVT = 32'h0C;
  localparam logic [31:0] OFF_IER  = 32'h10;

  localparam int LSR_RXNE   = 0;
  localparam int LSR_OE     = 1;
  localparam int LSR_PE     = 2;
  localparam int LSR_FE     = 3;
  localparam int LSR_TXNF   = 5;
  localparam int LSR_TXIDLE = 6;

  localparam int IER_RX = 0;
  localparam int IER_TX = 1;

  localparam logic [15:0] MIN_DIV   = 16'd2;
  localparam logic [15:0] DIV_RESET = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Word-granular match; byte lanes within a word are ignored.
  function automatic logic reg_hit(input logic [29:0] addr_w, input logic [31:0] base,
                                   input logic [31:0] off);
    logic [31:0] target;
    target = base + off;
    return addr_w == target[31:2];
  endfunction

  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

endpackage

// File: rtl/uart_buffered_if.sv
// CPU bridge bus seen by the UART: byte address, strobes, write data and
// combinational read data.
interface uart_buffered_if;
  logic [31:0] Addr;
  logic        WE;
  logic        RE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, output WE, output RE, output Din, input Dout);
  modport slave  (input Addr, input WE, input RE, input Din, output Dout);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered head; push on full is dropped unless a
// pop happens in the same cycle, pop on empty is ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign head    = mem_q[rptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d   = mem_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_buffered.sv
// Memory-mapped UART with RX/TX FIFOs, sticky line errors and maskable irq.
// Even parity is inserted/checked when UART_PARITY_EN is defined.
//   state     | meaning
//   ST_IDLE   | line idle, waiting for FIFO data (TX) or a falling rxd (RX)
//   ST_START  | start bit; RX samples it mid-bit to reject glitches
//   ST_DATA   | DATA_BITS data bits, LSB first
//   ST_PARITY | even parity bit (parity build only)
//   ST_STOP   | stop bit; TX chains straight into the next frame if queued
module uart_buffered
  import uart_buffered_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h7f30,
  parameter int          DATA_BITS  = 8,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rstn,
  uart_buffered_if.slave bus,
  input  logic           rxd,
  output logic           txd,
  output logic           irq
);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
  localparam uart_state_e AFTER_DATA = ST_PARITY;
`else
  localparam uart_state_e AFTER_DATA = ST_STOP;
`endif

  logic                 sel_data, sel_lsr, sel_divr, sel_divt, sel_ier;
  logic                 wr_data, rd_data, rd_lsr;
  logic [15:0]          divr_q, divr_d, divt_q, divt_d;
  logic [15:0]          divr_m1, divr_half_m1, divt_m1;
  logic [1:0]           ier_q, ier_d;
  logic                 oe_q, oe_d, pe_q, pe_d, fe_q, fe_d;
  logic                 oe_set, pe_set, fe_set;
  logic                 tx_full, tx_empty, tx_pop;
  logic                 rx_full, rx_empty, rx_push;
  logic [DATA_BITS-1:0] tx_head, rx_head;
  uart_state_e          tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [15:0]          tx_timer_q, tx_timer_d, rx_timer_q, rx_timer_d;
  logic                 tx_tc, rx_tc;
  logic [2:0]           tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d, rx_data_q, rx_data_d;
  logic                 tx_idle, rx_nonempty;
  logic [31:0]          lsr;

  assign sel_data = reg_hit(bus.Addr[31:2], BASE_ADDR, OFF_DATA);
  assign sel_lsr  = reg_hit(bus.Addr[31:2], BASE_ADDR, OFF_LSR);
  assign sel_divr = reg_hit(bus.Addr[31:2], BASE_ADDR, OFF_DIVR);
  assign sel_divt = reg_hit(bus.Addr[31:2], BASE_ADDR, OFF_DIVT);
  assign sel_ier  = reg_hit(bus.Addr[31:2], BASE_ADDR, OFF_IER);

  assign wr_data = bus.WE & sel_data;
  assign rd_data = bus.RE & sel_data;
  assign rd_lsr  = bus.RE & sel_lsr;

  // Divisors are sampled at every bit boundary, so writes land on the next bit.
  assign divt_m1      = eff_div(divt_q) - 16'd1;
  assign divr_m1      = eff_div(divr_q) - 16'd1;
  assign divr_half_m1 = (eff_div(divr_q) >> 1) - 16'd1;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (wr_data),
    .pop   (tx_pop),
    .wdata (bus.Din[DATA_BITS-1:0]),
    .full  (tx_full),
    .empty (tx_empty),
    .head  (tx_head)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_push),
    .pop   (rd_data),
    .wdata (rx_data_q),
    .full  (rx_full),
    .empty (rx_empty),
    .head  (rx_head)
  );

  assign tx_idle     = tx_empty & (tx_state_q == ST_IDLE);
  assign rx_nonempty = ~rx_empty;
  assign irq         = (ier_q[IER_RX] & rx_nonempty) | (ier_q[IER_TX] & tx_idle);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_data_d  = tx_data_q;
    tx_pop     = 1'b0;
    tx_tc      = (tx_timer_q == '0);
    tx_timer_d = tx_tc ? tx_timer_q : tx_timer_q - 16'd1;
    case (tx_state_q)
      ST_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_data_d  = tx_head;
          tx_timer_d = divt_m1;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_tc) begin
          tx_bit_d   = '0;
          tx_timer_d = divt_m1;
          tx_state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_tc) begin
          tx_timer_d = divt_m1;
          if (tx_bit_q == LAST_BIT) tx_state_d = AFTER_DATA;
          else                      tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (tx_tc) begin
          tx_timer_d = divt_m1;
          tx_state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tx_tc) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_data_d  = tx_head;
            tx_timer_d = divt_m1;
            tx_state_d = ST_START;
          end else begin
            tx_state_d = ST_IDLE;
          end
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (tx_state_q)
      ST_START:  txd = 1'b0;
      ST_DATA:   txd = tx_data_q[tx_bit_q];
      ST_PARITY: txd = ^tx_data_q;
      default:   txd = 1'b1;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_bit_d   = rx_bit_q;
    rx_data_d  = rx_data_q;
    rx_push    = 1'b0;
    oe_set     = 1'b0;
    pe_set     = 1'b0;
    fe_set     = 1'b0;
    rx_tc      = (rx_timer_q == '0);
    rx_timer_d = rx_tc ? rx_timer_q : rx_timer_q - 16'd1;
    case (rx_state_q)
      ST_IDLE: begin
        if (!rxd) begin
          rx_timer_d = divr_half_m1;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_tc) begin
          if (rxd) begin
            rx_state_d = ST_IDLE;
          end else begin
            rx_bit_d   = '0;
            rx_timer_d = divr_m1;
            rx_state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_tc) begin
          rx_data_d  = {rxd, rx_data_q[DATA_BITS-1:1]};
          rx_timer_d = divr_m1;
          if (rx_bit_q == LAST_BIT) rx_state_d = AFTER_DATA;
          else                      rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (rx_tc) begin
          pe_set     = (^rx_data_q) ^ rxd;
          rx_timer_d = divr_m1;
          rx_state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (rx_tc) begin
          rx_state_d = ST_IDLE;
          if (!rxd) begin
            fe_set = 1'b1;
          end else begin
            rx_push = 1'b1;
            oe_set  = rx_full & ~rd_data;
          end
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // A new error in the clearing cycle wins over the clear.
  always_comb begin
    divr_d = (bus.WE & sel_divr) ? bus.Din[15:0] : divr_q;
    divt_d = (bus.WE & sel_divt) ? bus.Din[15:0] : divt_q;
    ier_d  = (bus.WE & sel_ier)  ? bus.Din[1:0]  : ier_q;
    oe_d   = (oe_q & ~rd_lsr) | oe_set;
    pe_d   = (pe_q & ~rd_lsr) | pe_set;
    fe_d   = (fe_q & ~rd_lsr) | fe_set;
  end

  always_comb begin
    lsr             = '0;
    lsr[LSR_RXNE]   = rx_nonempty;
    lsr[LSR_OE]     = oe_q;
    lsr[LSR_PE]     = pe_q;
    lsr[LSR_FE]     = fe_q;
    lsr[LSR_TXNF]   = ~tx_full;
    lsr[LSR_TXIDLE] = tx_idle;
  end

  always_comb begin
    bus.Dout = '0;
    if (sel_data)      bus.Dout = rx_empty ? 32'd0 : 32'(rx_head);
    else if (sel_lsr)  bus.Dout = lsr;
    else if (sel_divr) bus.Dout = {16'd0, divr_q};
    else if (sel_divt) bus.Dout = {16'd0, divt_q};
    else if (sel_ier)  bus.Dout = {30'd0, ier_q};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      divr_q     <= DIV_RESET;
      divt_q     <= DIV_RESET;
      ier_q      <= 2'b01;
      oe_q       <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      tx_state_q <= ST_IDLE;
      tx_timer_q <= '0;
      tx_bit_q   <= '0;
      tx_data_q  <= '0;
      rx_state_q <= ST_IDLE;
      rx_timer_q <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
    end else begin
      divr_q     <= divr_d;
      divt_q     <= divt_d;
      ier_q      <= ier_d;
      oe_q       <= oe_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      tx_state_q <= tx_state_d;
      tx_timer_q <= tx_timer_d;
      tx_bit_q   <= tx_bit_d;
      tx_data_q  <= tx_data_d;
      rx_state_q <= rx_state_d;
      rx_timer_q <= rx_timer_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
    end
  end

endmodule

// File: tb/tb_uart_buffered.sv
// Directed + randomized bench for uart_buffered: TX line waveforms and RX
// FIFO/flag behaviour compared against a queue-based model of the UART.
module tb_uart_buffered;
  localparam int          DB    = 8;
  localparam int          DEPTH = 4;
  localparam int          DIVR  = 16;
  localparam logic [31:0] BASE  = 32'h7f30;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_LSR  = BASE + 32'h4;
  localparam logic [31:0] A_DIVR = BASE + 32'h8;
  localparam logic [31:0] A_DIVT = BASE + 32'hC;
  localparam logic [31:0] A_IER  = BASE + 32'h10;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rxd = 1'b1;
  logic txd, irq;
  int   tests = 0;
  int   fails = 0;

  logic [7:0]  rxq[$];
  logic        m_oe = 1'b0, m_pe = 1'b0, m_fe = 1'b0;
  logic [1:0]  m_ier = 2'b01;
  logic [31:0] v;
  logic [7:0]  bq[$];

  uart_buffered_if bus();

  uart_buffered #(.BASE_ADDR(BASE), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .rxd  (rxd),
    .txd  (txd),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.Addr = a; bus.Din = d; bus.WE = 1'b1;
    @(posedge clk); #1;
    bus.WE = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.Addr = a; bus.RE = 1'b1;
    #1 d = bus.Dout;
    @(posedge clk); #1;
    bus.RE = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    bus.Addr = a;
    #1 d = bus.Dout;
  endtask

  // Expected LSR with the transmitter idle.
  function automatic logic [31:0] model_lsr();
    logic [31:0] r;
    r = 32'h60;
    r[0] = (rxq.size() != 0);
    r[1] = m_oe;
    r[2] = m_pe;
    r[3] = m_fe;
    return r;
  endfunction

  function automatic logic model_irq();
    return (m_ier[0] & (rxq.size() != 0)) | m_ier[1];
  endfunction

  // Writes the bytes on consecutive cycles into an idle TX path, then checks
  // txd every cycle against the ideal serial stream.
  task automatic tx_burst(input string tag, input logic [7:0] bytes[$], input int divt);
    logic        exp_bits[$];
    logic [31:0] lsr;
    logic        e;
    int          n, acc, len, bad, cnt;
    n   = bytes.size();
    acc = (n > DEPTH + 1) ? DEPTH + 1 : n;
    for (int i = 0; i < acc; i++) begin
      exp_bits.push_back(1'b0);
      for (int b = 0; b < DB; b++) exp_bits.push_back(bytes[i][b]);
      if (PB == 1) exp_bits.push_back(^bytes[i]);
      exp_bits.push_back(1'b1);
    end
    len = exp_bits.size() * divt;
    for (int i = 0; i < n; i++) wr(A_DATA, {24'h0, bytes[i]});
    cnt = (n == 1) ? 1 : acc - 1;
    peek(A_LSR, lsr);
    check({tag, "_tx_not_full"}, {31'b0, lsr[5]}, {31'b0, (cnt < DEPTH)});
    check({tag, "_tx_busy"}, {31'b0, lsr[6]}, 32'd0);
    bad = 0;
    for (int k = n - 1; k < len + 2 * divt; k++) begin
      cycles(1);
      e = (k < len) ? exp_bits[k / divt] : 1'b1;
      if (txd !== e) bad++;
    end
    check({tag, "_wave_bad_cycles"}, bad, 0);
    peek(A_LSR, lsr);
    check({tag, "_tx_idle_after"}, {31'b0, lsr[6]}, 32'd1);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic par, input logic stop);
    rxd = 1'b0; cycles(DIVR);
    for (int b = 0; b < DB; b++) begin
      rxd = d[b]; cycles(DIVR);
    end
    if (PB == 1) begin
      rxd = par; cycles(DIVR);
    end
    rxd = stop; cycles(DIVR);
    rxd = 1'b1; cycles(12);
    if (PB == 1 && par != ^d) m_pe = 1'b1;
    if (!stop) m_fe = 1'b1;
    else if (rxq.size() < DEPTH) rxq.push_back(d);
    else m_oe = 1'b1;
  endtask

  initial begin
    bus.Addr = '0; bus.WE = 1'b0; bus.RE = 1'b0; bus.Din = '0;
    cycles(3);
    rstn = 1'b1;

    // Reset state
    check("reset_txd", {31'b0, txd}, 32'd1);
    check("reset_irq", {31'b0, irq}, 32'd0);
    peek(A_LSR, v);  check("reset_lsr", v, 32'h60);
    peek(A_DIVR, v); check("reset_divr", v, 32'hFFFF);
    peek(A_DIVT, v); check("reset_divt", v, 32'hFFFF);
    peek(A_IER, v);  check("reset_ier", v, 32'h1);
    peek(A_DATA, v); check("reset_data_empty", v, 32'h0);
    peek(BASE + 32'h14, v); check("unmapped_above", v, 32'h0);
    peek(BASE - 32'h4, v);  check("unmapped_below", v, 32'h0);

    wr(A_DIVT, 32'h0001_0010);
    wr(A_DIVR, DIVR);
    peek(A_DIVT, v); check("divt_readback", v, 32'h10);
    peek(A_DIVR, v); check("divr_readback", v, DIVR);

    // Single 0x55 frame
    bq = {8'h55};
    tx_burst("tx55", bq, 16);

    // Six back-to-back writes: five frames, the sixth is dropped on full
    bq.delete();
    for (int i = 0; i < 6; i++) bq.push_back(8'($urandom));
    tx_burst("tx_burst6", bq, 16);

    // Divisor below minimum behaves as 2
    wr(A_DIVT, 32'h0);
    peek(A_DIVT, v); check("divt_zero_readback", v, 32'h0);
    bq = {8'($urandom)};
    tx_burst("tx_div0", bq, 2);
    wr(A_DIVT, 32'h10);

`ifdef UART_PARITY_EN
    bq = {8'h07};
    tx_burst("tx_par07", bq, 16);
`endif

    // TX-idle interrupt source
    wr(A_IER, 32'h2); m_ier = 2'b10;
    check("irq_txidle", {31'b0, irq}, {31'b0, model_irq()});
    wr(A_IER, 32'h1); m_ier = 2'b01;
    check("irq_rx_only_empty", {31'b0, irq}, {31'b0, model_irq()});

    // Five RX frames with no reads: overrun
    for (int i = 0; i < 5; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      rx_frame(d, ^d, 1'b1);
    end
    peek(A_LSR, v); check("rx_overrun_lsr", v, model_lsr());
    check("rx_overrun_irq", {31'b0, irq}, {31'b0, model_irq()});
    wr(A_IER, 32'h0); m_ier = 2'b00;
    check("irq_masked", {31'b0, irq}, {31'b0, model_irq()});
    wr(A_IER, 32'h1); m_ier = 2'b01;
    rd(A_LSR, v); check("lsr_read_value", v, model_lsr());
    m_oe = 1'b0; m_pe = 1'b0; m_fe = 1'b0;
    peek(A_LSR, v); check("lsr_after_clear", v, model_lsr());
    while (rxq.size() != 0) begin
      rd(A_DATA, v); check("rx_data_order", v, {24'h0, rxq.pop_front()});
    end
    rd(A_DATA, v); check("rx_data_empty", v, 32'h0);
    peek(A_LSR, v); check("rx_drained_lsr", v, model_lsr());
    check("rx_drained_irq", {31'b0, irq}, {31'b0, model_irq()});

    // Framing error keeps the FIFO unchanged
    begin
      logic [7:0] d;
      d = 8'($urandom);
      rx_frame(d, ^d, 1'b1);
      d = 8'($urandom);
      rx_frame(d, ^d, 1'b0);
    end
    cycles(10);
    peek(A_LSR, v); check("rx_fe_lsr", v, model_lsr());
    rd(A_LSR, v); m_fe = 1'b0;
    rd(A_DATA, v); check("rx_fe_data", v, {24'h0, rxq.pop_front()});
    peek(A_LSR, v); check("rx_fe_cleared", v, model_lsr());

    // Short glitch on rxd
    rxd = 1'b0; cycles(3);
    rxd = 1'b1; cycles(30);
    peek(A_LSR, v); check("rx_glitch_lsr", v, model_lsr());
    peek(A_DATA, v); check("rx_glitch_data", v, 32'h0);

`ifdef UART_PARITY_EN
    rx_frame(8'h03, 1'b1, 1'b1);
    peek(A_LSR, v); check("rx_parity_lsr", v, model_lsr());
    rd(A_LSR, v); m_pe = 1'b0;
    rd(A_DATA, v); check("rx_parity_data", v, {24'h0, rxq.pop_front()});
`endif

    // Reset in the middle of a TX data bit with both FIFOs occupied
    begin
      logic [7:0] d;
      d = 8'($urandom);
      rx_frame(d, ^d, 1'b1);
    end
    for (int i = 0; i < 3; i++) wr(A_DATA, $urandom);
    cycles(40);
    peek(A_LSR, v); check("pre_reset_lsr", v, model_lsr() & ~32'h40);
    rstn = 1'b0;
    cycles(1);
    check("reset_mid_txd", {31'b0, txd}, 32'd1);
    peek(A_LSR, v); check("reset_mid_lsr", v, 32'h60);
    check("reset_mid_irq", {31'b0, irq}, 32'd0);
    rstn = 1'b1;
    rxq.delete(); m_oe = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_ier = 2'b01;
    cycles(50);
    check("post_reset_txd", {31'b0, txd}, 32'd1);
    peek(A_LSR, v); check("post_reset_lsr", v, model_lsr());
    peek(A_DIVT, v); check("post_reset_divt", v, 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
